// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp), compares both words against expected values and reports
// match/mismatch/timeout status plus a saturating error count to board logic.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1393542708,
    parameter int unsigned RECHECK_CYCLES     = 50000000,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        recheck,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        done,
    output logic        match,
    output logic        mismatch,
    output logic        timeout,
    output logic [7:0]  error_count
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STALL_W = 16;
    localparam int unsigned ERR_W   = 8;

    // Interval reload value; a zero period disables automatic re-checks entirely.
    localparam logic             RECHECK_EN = (RECHECK_CYCLES != 0);
    localparam logic [CNT_W-1:0] RELOAD     = RECHECK_EN ? CNT_W'(RECHECK_CYCLES - 1) : '0;
    // Stall count value at which the next stalled edge declares a timeout.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_CHECK,
        S_WAIT
    } state_t;

    state_t              r_state,    w_state;
    logic                r_read,     w_read;
    logic                r_addr,     w_addr;
    logic [DATA_W-1:0]   r_id,       w_id;
    logic [DATA_W-1:0]   r_ts,       w_ts;
    logic                r_done,     w_done;
    logic                r_match,    w_match;
    logic                r_mismatch, w_mismatch;
    logic                r_timeout,  w_timeout;
    logic [ERR_W-1:0]    r_err,      w_err;
    logic                r_to_flag,  w_to_flag;
    logic [STALL_W-1:0]  r_stall,    w_stall;
    logic [CNT_W-1:0]    r_interval, w_interval;

    logic w_stall_hit;
    logic w_pass;
    logic w_start;

    assign w_stall_hit = avm_waitrequest && (r_stall == STALL_LAST);
    assign w_pass      = (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TIMESTAMP) && !r_to_flag;
    assign w_start     = recheck || (RECHECK_EN && (r_interval == '0));

    // State and all registered outputs/timers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_read     <= 1'b0;
            r_addr     <= 1'b0;
            r_id       <= '0;
            r_ts       <= '0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= '0;
            r_to_flag  <= 1'b0;
            r_stall    <= '0;
            r_interval <= '0;
        end else begin
            r_state    <= w_state;
            r_read     <= w_read;
            r_addr     <= w_addr;
            r_id       <= w_id;
            r_ts       <= w_ts;
            r_done     <= w_done;
            r_match    <= w_match;
            r_mismatch <= w_mismatch;
            r_timeout  <= w_timeout;
            r_err      <= w_err;
            r_to_flag  <= w_to_flag;
            r_stall    <= w_stall;
            r_interval <= w_interval;
        end
    end

    // Next-state and next-register logic for the read/compare sequence.
    always_comb begin
        w_state    = r_state;
        w_read     = r_read;
        w_addr     = r_addr;
        w_id       = r_id;
        w_ts       = r_ts;
        w_done     = r_done;
        w_match    = r_match;
        w_mismatch = r_mismatch;
        w_timeout  = r_timeout;
        w_err      = r_err;
        w_to_flag  = r_to_flag;
        w_stall    = r_stall;
        w_interval = r_interval;

        case (r_state)
            S_IDLE: begin
                w_state   = S_RD_ID;
                w_read    = 1'b1;
                w_addr    = 1'b0;
                w_stall   = '0;
                w_to_flag = 1'b0;
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    w_id    = avm_readdata;
                    w_addr  = 1'b1;
                    w_stall = '0;
                    w_state = S_RD_TS;
                end else if (w_stall_hit) begin
                    // Abort: the timestamp read is skipped, captures stay as they were.
                    w_read    = 1'b0;
                    w_addr    = 1'b0;
                    w_to_flag = 1'b1;
                    w_stall   = '0;
                    w_state   = S_CHECK;
                end else begin
                    w_stall = r_stall + STALL_W'(1);
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    w_ts    = avm_readdata;
                    w_read  = 1'b0;
                    w_addr  = 1'b0;
                    w_stall = '0;
                    w_state = S_CHECK;
                end else if (w_stall_hit) begin
                    w_read    = 1'b0;
                    w_addr    = 1'b0;
                    w_to_flag = 1'b1;
                    w_stall   = '0;
                    w_state   = S_CHECK;
                end else begin
                    w_stall = r_stall + STALL_W'(1);
                end
            end
            S_CHECK: begin
                w_done     = 1'b1;
                w_match    = w_pass;
                w_mismatch = !w_pass;
                w_timeout  = r_to_flag;
                if (!w_pass && (r_err != ERR_MAX)) begin
                    w_err = r_err + ERR_W'(1);
                end
                w_interval = RELOAD;
                w_state    = S_WAIT;
            end
            S_WAIT: begin
                if (w_start) begin
                    w_state   = S_RD_ID;
                    w_read    = 1'b1;
                    w_addr    = 1'b0;
                    w_stall   = '0;
                    w_to_flag = 1'b0;
                end else if (RECHECK_EN && (r_interval != '0)) begin
                    w_interval = r_interval - CNT_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_read  = 1'b0;
                w_addr  = 1'b0;
            end
        endcase
    end

    assign avm_read        = r_read;
    assign avm_address     = r_addr;
    assign id_value        = r_id;
    assign timestamp_value = r_ts;
    assign done            = r_done;
    assign match           = r_match;
    assign mismatch        = r_mismatch;
    assign timeout         = r_timeout;
    assign error_count     = r_err;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed testbench for sysid_checker. Instance A (no auto re-check, 4-cycle timeout)
// covers reset timing, stalls, recheck handling, timeout and mid-read reset; instance B
// (10-cycle re-check, wrong timestamp) covers mismatch reporting and error saturation.
module tb_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1393542708;
    localparam logic [31:0] TS_BAD  = 32'd1393542709;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A signals
    logic        a_reset_n = 1'b0;
    logic        a_recheck = 1'b0;
    logic        a_waitreq = 1'b0;
    logic        a_address;
    logic        a_read;
    logic [31:0] a_readdata;
    logic [31:0] a_id;
    logic [31:0] a_ts;
    logic        a_done;
    logic        a_match;
    logic        a_mismatch;
    logic        a_timeout;
    logic [7:0]  a_err;

    // Instance B signals
    logic        b_reset_n = 1'b0;
    logic        b_recheck = 1'b0;
    logic        b_waitreq = 1'b0;
    logic        b_address;
    logic        b_read;
    logic [31:0] b_readdata;
    logic [31:0] b_id;
    logic [31:0] b_ts;
    logic        b_done;
    logic        b_match;
    logic        b_mismatch;
    logic        b_timeout;
    logic [7:0]  b_err;

    // System-ID slave models: A returns the correct image, B a stale timestamp.
    assign a_readdata = a_address ? TS_GOOD : 32'd0;
    assign b_readdata = b_address ? TS_BAD  : 32'd0;

    sysid_checker #(
        .RECHECK_CYCLES (0),
        .TIMEOUT_CYCLES (4)
    ) u_dut_a (
        .clock           (clock),
        .reset_n         (a_reset_n),
        .recheck         (a_recheck),
        .avm_address     (a_address),
        .avm_read        (a_read),
        .avm_readdata    (a_readdata),
        .avm_waitrequest (a_waitreq),
        .id_value        (a_id),
        .timestamp_value (a_ts),
        .done            (a_done),
        .match           (a_match),
        .mismatch        (a_mismatch),
        .timeout         (a_timeout),
        .error_count     (a_err)
    );

    sysid_checker #(
        .RECHECK_CYCLES (10)
    ) u_dut_b (
        .clock           (clock),
        .reset_n         (b_reset_n),
        .recheck         (b_recheck),
        .avm_address     (b_address),
        .avm_read        (b_read),
        .avm_readdata    (b_readdata),
        .avm_waitrequest (b_waitreq),
        .id_value        (b_id),
        .timestamp_value (b_ts),
        .done            (b_done),
        .match           (b_match),
        .mismatch        (b_mismatch),
        .timeout         (b_timeout),
        .error_count     (b_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- Instance B: mismatch and error saturation ----------------
        tick();
        check("a_rst_read",  32'(a_read), 32'd0);
        check("a_rst_done",  32'(a_done), 32'd0);
        check("b_rst_err",   32'(b_err),  32'd0);
        b_reset_n = 1'b1;
        repeat (4) tick();                              // edge 4
        check("b_e4_done",     32'(b_done),     32'd1);
        check("b_e4_mismatch", 32'(b_mismatch), 32'd1);
        check("b_e4_match",    32'(b_match),    32'd0);
        check("b_e4_timeout",  32'(b_timeout),  32'd0);
        check("b_e4_err",      32'(b_err),      32'd1);
        check("b_e4_ts",       b_ts,            TS_BAD);
        repeat (12) tick();                             // edge 16
        check("b_e16_err", 32'(b_err), 32'd1);
        tick();                                         // edge 17
        check("b_e17_err", 32'(b_err), 32'd2);
        repeat (3305 - 17) tick();                      // edge 3305
        check("b_e3305_err", 32'(b_err), 32'd254);
        tick();                                         // edge 3306
        check("b_e3306_err", 32'(b_err), 32'd255);
        repeat (3900 - 3306) tick();                    // edge 3900, 300 checks done
        check("b_sat_err",      32'(b_err),      32'd255);
        check("b_sat_mismatch", 32'(b_mismatch), 32'd1);

        // ---------------- Instance A: reset state after long hold ----------------
        check("a_rst_addr",     32'(a_address),  32'd0);
        check("a_rst_id",       a_id,            32'd0);
        check("a_rst_ts",       a_ts,            32'd0);
        check("a_rst_match",    32'(a_match),    32'd0);
        check("a_rst_mismatch", 32'(a_mismatch), 32'd0);
        check("a_rst_timeout",  32'(a_timeout),  32'd0);
        check("a_rst_err",      32'(a_err),      32'd0);

        // ---------------- A: clean check after reset release ----------------
        a_reset_n = 1'b1;
        tick();                                         // edge 1
        check("a_e1_read", 32'(a_read),    32'd1);
        check("a_e1_addr", 32'(a_address), 32'd0);
        tick();                                         // edge 2
        check("a_e2_addr", 32'(a_address), 32'd1);
        check("a_e2_read", 32'(a_read),    32'd1);
        check("a_e2_id",   a_id,           32'd0);
        tick();                                         // edge 3
        check("a_e3_read", 32'(a_read), 32'd0);
        check("a_e3_ts",   a_ts,        TS_GOOD);
        check("a_e3_done", 32'(a_done), 32'd0);
        tick();                                         // edge 4
        check("a_e4_done",     32'(a_done),     32'd1);
        check("a_e4_match",    32'(a_match),    32'd1);
        check("a_e4_mismatch", 32'(a_mismatch), 32'd0);
        check("a_e4_timeout",  32'(a_timeout),  32'd0);
        check("a_e4_err",      32'(a_err),      32'd0);
        repeat (5) tick();
        check("a_wait_idle_read", 32'(a_read), 32'd0);

        // ---------------- A: 3-cycle stall on the ID read ----------------
        a_reset_n = 1'b0;
        a_waitreq = 1'b1;
        tick();
        a_reset_n = 1'b1;
        tick();                                         // edge 1
        check("st_e1_read", 32'(a_read), 32'd1);
        for (int e = 2; e <= 4; e++) begin
            tick();                                     // edges 2..4 stalled
            check("st_hold_read", 32'(a_read),    32'd1);
            check("st_hold_addr", 32'(a_address), 32'd0);
        end
        a_waitreq = 1'b0;
        tick();                                         // edge 5
        check("st_e5_addr", 32'(a_address), 32'd1);
        tick();                                         // edge 6
        check("st_e6_read", 32'(a_read), 32'd0);
        check("st_e6_done", 32'(a_done), 32'd0);
        tick();                                         // edge 7
        check("st_e7_done",  32'(a_done),  32'd1);
        check("st_e7_match", 32'(a_match), 32'd1);

        // ---------------- A: recheck ignored in RD_TS, honoured in WAIT ----------------
        a_reset_n = 1'b0;
        tick();
        a_reset_n = 1'b1;
        tick();                                         // edge 1, RD_ID
        tick();                                         // edge 2, RD_TS
        a_recheck = 1'b1;
        tick();                                         // edge 3, recheck ignored
        a_recheck = 1'b0;
        tick();                                         // edge 4, WAIT
        check("rc_e4_done", 32'(a_done), 32'd1);
        repeat (3) tick();
        check("rc_not_queued", 32'(a_read), 32'd0);
        a_recheck = 1'b1;
        tick();
        a_recheck = 1'b0;
        check("rc_start_read", 32'(a_read),    32'd1);
        check("rc_start_addr", 32'(a_address), 32'd0);
        tick();
        check("rc_ts_addr", 32'(a_address), 32'd1);
        tick();
        check("rc_end_read", 32'(a_read), 32'd0);
        tick();
        check("rc_match", 32'(a_match), 32'd1);
        repeat (2) tick();
        check("rc_single_seq", 32'(a_read), 32'd0);

        // ---------------- A: timeout with flags held during the re-check ----------------
        a_waitreq = 1'b1;
        a_recheck = 1'b1;
        tick();                                         // R1
        a_recheck = 1'b0;
        check("to_r1_read",  32'(a_read),  32'd1);
        check("to_r1_match", 32'(a_match), 32'd1);
        repeat (3) tick();                              // R4, 3 stalled edges
        check("to_r4_read",    32'(a_read),    32'd1);
        check("to_r4_timeout", 32'(a_timeout), 32'd0);
        check("to_r4_match",   32'(a_match),   32'd1);
        tick();                                         // R5, 4th stalled edge
        check("to_r5_read", 32'(a_read), 32'd0);
        tick();                                         // R6, CHECK exit
        check("to_timeout",  32'(a_timeout),  32'd1);
        check("to_mismatch", 32'(a_mismatch), 32'd1);
        check("to_match",    32'(a_match),    32'd0);
        check("to_err",      32'(a_err),      32'd1);
        check("to_id",       a_id,            32'd0);
        a_waitreq = 1'b0;

        // ---------------- A: reset asserted while in RD_TS ----------------
        a_recheck = 1'b1;
        tick();
        a_recheck = 1'b0;
        tick();                                         // RD_TS
        check("mr_rdts_addr", 32'(a_address), 32'd1);
        #2;
        a_reset_n = 1'b0;
        #1;
        check("mr_read",    32'(a_read),     32'd0);
        check("mr_addr",    32'(a_address),  32'd0);
        check("mr_done",    32'(a_done),     32'd0);
        check("mr_timeout", 32'(a_timeout),  32'd0);
        check("mr_mism",    32'(a_mismatch), 32'd0);
        check("mr_err",     32'(a_err),      32'd0);
        check("mr_ts",      a_ts,            32'd0);
        a_reset_n = 1'b1;
        tick();                                         // edge 1
        check("mr_e1_read", 32'(a_read), 32'd1);
        repeat (3) tick();                              // edge 4
        check("mr_e4_done",  32'(a_done),  32'd1);
        check("mr_e4_match", 32'(a_match), 32'd1);
        check("mr_e4_ts",    a_ts,         TS_GOOD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
